// File: rtl/burst_sched_pkg.sv
// burst_sched_pkg: shared defaults, widths and state types for the burst credit scheduler
package burst_sched_pkg;
   localparam int N_CH_D    = 4;
   localparam int CNT_MAX_D = 24;
   localparam int DIV_D     = 4;
   localparam int CRD_MAX_D = 15;
   localparam int CNT_W     = $clog2(CNT_MAX_D + 1);
   localparam int CRD_W     = $clog2(CRD_MAX_D + 1);
   typedef enum logic {M_IDLE, M_COUNT} meas_state_t;
   typedef enum logic {S_IDLE, S_SERVE} sched_state_t;
endpackage

// File: rtl/burst_meter.sv
// burst_meter: measures one channel's burst length and accumulates saturating pending credit
module burst_meter
   import burst_sched_pkg::*;
#(
   parameter int CNT_MAX = CNT_MAX_D,
   parameter int DIV     = DIV_D,
   parameter int CRD_MAX = CRD_MAX_D
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             in,
   input  logic                             clr,
   output logic [$clog2(CRD_MAX + 1)-1:0]   pend,
   output logic                             drop
);
   localparam int cnt_w = $clog2(CNT_MAX + 1);
   localparam int crd_w = $clog2(CRD_MAX + 1);
   localparam int sum_w = (cnt_w > crd_w ? cnt_w : crd_w) + 1;
   localparam int sh    = $clog2(DIV);
   meas_state_t      state;
   logic [cnt_w-1:0] cnt;
   logic [cnt_w-1:0] credit;
   logic [crd_w-1:0] base;
   logic [sum_w-1:0] sum;
   logic             done;
   logic             clip;
   // a grant in the same cycle as a completion starts the new total from zero
   always_comb begin
      done   = (state == M_COUNT) && !in;
      credit = cnt >> sh;
      base   = clr ? '0 : pend;
      sum    = sum_w'(base) + sum_w'(credit);
      clip   = sum > sum_w'(CRD_MAX);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= M_IDLE;
         cnt   <= '0;
         pend  <= '0;
         drop  <= 1'b0;
      end else begin
         drop <= 1'b0;
         if (state == M_IDLE) begin
            if (in) begin
               state <= M_COUNT;
               cnt   <= cnt_w'(1);
            end
         end else if (in) begin
            cnt <= (cnt == cnt_w'(CNT_MAX)) ? cnt : cnt + 1'b1;
         end else begin
            state <= M_IDLE;
            cnt   <= '0;
         end
         if (done && credit != '0) begin
            pend <= clip ? crd_w'(CRD_MAX) : sum[crd_w-1:0];
            drop <= clip;
         end else if (clr) begin
            pend <= '0;
         end
      end
   end
endmodule

// File: rtl/burst_credit_sched.sv
// burst_credit_sched: per-channel burst metering with round-robin service of credits on one shared pulse line
module burst_credit_sched
   import burst_sched_pkg::*;
#(
   parameter int N_CH    = N_CH_D,
   parameter int CNT_MAX = CNT_MAX_D,
   parameter int DIV     = DIV_D,
   parameter int CRD_MAX = CRD_MAX_D
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [N_CH-1:0]             in,
   output logic                        out,
   output logic [$clog2(N_CH)-1:0]     out_ch,
   output logic                        busy,
   output logic                        drop
);
   localparam int ch_w  = $clog2(N_CH);
   localparam int crd_w = $clog2(CRD_MAX + 1);
   logic [crd_w-1:0] pend [N_CH];
   logic [N_CH-1:0]  clr;
   logic [N_CH-1:0]  drops;
   sched_state_t     state;
   logic [ch_w-1:0]  ptr;
   logic [ch_w-1:0]  gnt;
   logic [crd_w-1:0] rem;
   logic             found;
   for (genvar i = 0; i < N_CH; i++) begin : g_meter
      burst_meter #(.CNT_MAX(CNT_MAX), .DIV(DIV), .CRD_MAX(CRD_MAX)) u_meter (
         .clk   (clk),
         .reset (reset),
         .in    (in[i]),
         .clr   (clr[i]),
         .pend  (pend[i]),
         .drop  (drops[i])
      );
   end
   // search starts one past the last served channel so every channel gets a turn
   always_comb begin
      found = 1'b0;
      gnt   = '0;
      for (int k = 1; k <= N_CH; k++) begin
         if (!found && pend[(int'(ptr) + k) % N_CH] != '0) begin
            found = 1'b1;
            gnt   = ch_w'((int'(ptr) + k) % N_CH);
         end
      end
      clr = (state == S_IDLE && found) ? (N_CH'(1) << gnt) : '0;
   end
   assign out  = (state == S_SERVE);
   assign busy = out;
   assign drop = |drops;
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         ptr    <= ch_w'(N_CH - 1);
         rem    <= '0;
         out_ch <= '0;
      end else if (state == S_IDLE) begin
         if (found) begin
            state  <= S_SERVE;
            ptr    <= gnt;
            out_ch <= gnt;
            rem    <= pend[gnt];
         end
      end else if (rem == crd_w'(1)) begin
         state  <= S_IDLE;
         out_ch <= '0;
         rem    <= '0;
      end else begin
         rem <= rem - 1'b1;
      end
   end
endmodule

// File: tb/tb_burst_credit_sched.sv
// tb_burst_credit_sched: directed cycle-by-cycle checks of metering, arbitration, clipping and reset
module tb_burst_credit_sched;
   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] in_a, in_b;
   logic       out_a, busy_a, drop_a, out_b, busy_b, drop_b;
   logic [1:0] out_ch_a, out_ch_b;
   int         vectors = 0;
   int         miscompares = 0;

   always #5 clk = ~clk;

   burst_credit_sched #(.N_CH(4), .CNT_MAX(24), .DIV(4), .CRD_MAX(15)) dut_a (
      .clk(clk), .reset(reset), .in(in_a), .out(out_a), .out_ch(out_ch_a), .busy(busy_a), .drop(drop_a)
   );
   burst_credit_sched #(.N_CH(4), .CNT_MAX(24), .DIV(1), .CRD_MAX(15)) dut_b (
      .clk(clk), .reset(reset), .in(in_b), .out(out_b), .out_ch(out_ch_b), .busy(busy_b), .drop(drop_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int c, input logic [4:0] obs, input logic [4:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s cycle %0d: observed {out,busy,out_ch,drop}=%b expected %b", tag, c, obs, exp);
      end
   endtask

   task automatic cyc_a(input string tag, input int c, input logic eo, input logic [1:0] ech, input logic ed);
      chk(tag, c, {out_a, busy_a, out_ch_a, drop_a}, {eo, eo, eo ? ech : 2'd0, ed});
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_a  = '0;
      in_b  = '0;
      tick();
      tick();
      reset = 1'b0;
      chk("reset_a", 0, {out_a, busy_a, out_ch_a, drop_a}, 5'b0);
      chk("reset_b", 0, {out_b, busy_b, out_ch_b, drop_b}, 5'b0);
   endtask

   initial begin
      reset = 1'b1;
      in_a  = '0;
      in_b  = '0;
      // single 8-cycle burst on ch0: two credits, out at cycles 10-11
      do_reset();
      for (int c = 0; c < 16; c++) begin
         in_a = (c < 8) ? 4'b0001 : 4'b0000;
         cyc_a("single", c, c == 10 || c == 11, 2'd0, 1'b0);
         tick();
      end
      // 3-cycle burst is below one credit
      do_reset();
      for (int c = 0; c < 20; c++) begin
         in_a = (c < 3) ? 4'b0010 : 4'b0000;
         cyc_a("short", c, 1'b0, 2'd0, 1'b0);
         tick();
      end
      // 30-cycle burst saturates at 24 -> 6 credits, out at 32..37
      do_reset();
      for (int c = 0; c < 40; c++) begin
         in_a = (c < 30) ? 4'b0100 : 4'b0000;
         cyc_a("sat", c, c >= 32 && c <= 37, 2'd2, 1'b0);
         tick();
      end
      // simultaneous ch0/ch3 completions twice: ch0 then ch3 in both rounds
      do_reset();
      for (int c = 0; c < 36; c++) begin
         in_a = ((c < 8) || (c >= 18 && c < 26)) ? 4'b1001 : 4'b0000;
         cyc_a("rr", c,
               (c == 10 || c == 11 || c == 13 || c == 14 || c == 28 || c == 29 || c == 31 || c == 32),
               (c == 13 || c == 14 || c == 31 || c == 32) ? 2'd3 : 2'd0, 1'b0);
         tick();
      end
      // DIV=1: 24 credits clip to 15, drop at 25, out 26..40 on ch1
      do_reset();
      for (int c = 0; c < 44; c++) begin
         in_b = (c < 24) ? 4'b0010 : 4'b0000;
         chk("clip", c, {out_b, busy_b, out_ch_b, drop_b},
             {(c >= 26 && c <= 40), (c >= 26 && c <= 40), (c >= 26 && c <= 40) ? 2'd1 : 2'd0, c == 25});
         tick();
      end
      // reset during the 3rd high cycle of a ch2 grant while ch1 holds pending credit
      do_reset();
      for (int c = 0; c < 60; c++) begin
         in_a  = {1'b0, c < 30, c >= 24 && c < 32, 1'b0};
         reset = (c == 34);
         cyc_a("rst_mid", c, c >= 32 && c <= 34, 2'd2, 1'b0);
         tick();
      end
      reset = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
